// File: rtl/write_mem_burst_pkg.sv
// Shared types for the burst write initiator: FSM states, address stride and the
// registered memory request bundle.
package write_mem_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STALL,
    ST_ISSUE,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int unsigned WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        last;
  } mem_req_t;

endpackage

// File: rtl/write_mem_burst_if.sv
// Data-memory write request port. The initiator drives requests and the memory
// answers with a per-word acknowledge (plus an error flag when WRITE_MEM_BURST_ERR_EN).
interface write_mem_burst_if;

  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic        mem_req_last;
  logic        mem_result_valid;
`ifdef WRITE_MEM_BURST_ERR_EN
  logic        mem_result_err;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_be, mem_we, mem_req_last,
    input  mem_result_valid, mem_result_err
  );
  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_be, mem_we, mem_req_last,
    output mem_result_valid, mem_result_err
  );
`else
  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_be, mem_we, mem_req_last,
    input  mem_result_valid
  );
  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_be, mem_we, mem_req_last,
    output mem_result_valid
  );
`endif

endinterface

// File: rtl/write_mem_fifo.sv
// Synchronous word FIFO between the write-data stream and the memory port.
// Exposes the head and the entry behind it so the issuer can chain words on an ack.
module write_mem_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [DATA_W-1:0] next_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              multi_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, count;
  logic [AW-1:0]     rd_idx_next;
  logic              do_push, do_pop;

  assign count       = wr_ptr - rd_ptr;
  assign empty_o     = (wr_ptr == rd_ptr);
  assign full_o      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign multi_o     = (count >= PW'(2));
  assign rd_idx_next = rd_ptr[AW-1:0] + AW'(1);
  assign head_o      = mem_q[rd_ptr[AW-1:0]];
  assign next_o      = mem_q[rd_idx_next];

  // A pop frees the head slot in the same cycle, so a push at full is allowed then.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/write_mem_burst.sv
// Burst memory write initiator: one command, len_i+1 streamed words, one acked write per word.
// Optional abort-on-error path enabled by defining WRITE_MEM_BURST_ERR_EN.
module write_mem_burst
  import write_mem_burst_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [31:0]      addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [3:0]       be_i,
  input  logic             s_valid_i,
  input  logic [31:0]      s_data_i,
  output logic             s_ready_o,
  output logic             busy_o,
  output logic             done_o,
`ifdef WRITE_MEM_BURST_ERR_EN
  output logic             err_o,
`endif
  write_mem_burst_if.master mem
);

  localparam int CW = LEN_W + 1;

  state_t        state;
  mem_req_t      req;
  logic          req_vld;
  logic [CW-1:0] accept_cnt, issue_cnt;
  logic [31:0]   addr_q, addr_nxt;
  logic [3:0]    be_q;
  logic [31:0]   fifo_head, fifo_next;
  logic          fifo_full, fifo_empty, fifo_multi;
  logic          fifo_push, ack, ack_ok, ack_err;

  assign ack = (state == ST_ISSUE) & req_vld & mem.mem_result_valid;
`ifdef WRITE_MEM_BURST_ERR_EN
  assign ack_err = ack & mem.mem_result_err;
`else
  assign ack_err = 1'b0;
`endif
  assign ack_ok    = ack & ~ack_err;
  assign addr_nxt  = addr_q + 32'(WORD_BYTES);
  assign s_ready_o = busy_o & ~fifo_full & (accept_cnt != '0);
  assign fifo_push = s_valid_i & s_ready_o;

  write_mem_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (32)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (ack_err),
    .push_i  (fifo_push),
    .wdata_i (s_data_i),
    .pop_i   (ack_ok),
    .head_o  (fifo_head),
    .next_o  (fifo_next),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .multi_o (fifo_multi)
  );

  assign mem.mem_valid    = req_vld;
  assign mem.mem_addr     = req.addr;
  assign mem.mem_wdata    = req.wdata;
  assign mem.mem_be       = req.be;
  assign mem.mem_req_last = req.last;
  assign mem.mem_we       = req_vld;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      req        <= '0;
      req_vld    <= 1'b0;
      accept_cnt <= '0;
      issue_cnt  <= '0;
      addr_q     <= '0;
      be_q       <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
`ifdef WRITE_MEM_BURST_ERR_EN
      err_o      <= 1'b0;
`endif
    end else begin
      if (fifo_push) accept_cnt <= accept_cnt - CW'(1);
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            addr_q     <= addr_i;
            be_q       <= be_i;
            accept_cnt <= CW'(len_i) + CW'(1);
            issue_cnt  <= CW'(len_i) + CW'(1);
            busy_o     <= 1'b1;
            state      <= ST_STALL;
          end
        end
        // FIFO writes only become visible here one cycle after the push.
        ST_STALL: begin
          if (!fifo_empty) begin
            req     <= '{addr: addr_q, wdata: fifo_head, be: be_q, last: (issue_cnt == CW'(1))};
            req_vld <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (ack_err) begin
            req        <= '0;
            req_vld    <= 1'b0;
            accept_cnt <= '0;
            done_o     <= 1'b1;
`ifdef WRITE_MEM_BURST_ERR_EN
            err_o      <= 1'b1;
`endif
            state      <= ST_ERROR;
          end else if (ack_ok) begin
            issue_cnt <= issue_cnt - CW'(1);
            addr_q    <= addr_nxt;
            if (issue_cnt == CW'(1)) begin
              req     <= '0;
              req_vld <= 1'b0;
              done_o  <= 1'b1;
              state   <= ST_DONE;
            end else if (fifo_multi) begin
              req <= '{addr: addr_nxt, wdata: fifo_next, be: be_q, last: (issue_cnt == CW'(2))};
            end else begin
              req     <= '0;
              req_vld <= 1'b0;
              state   <= ST_STALL;
            end
          end
        end
        ST_DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
`ifdef WRITE_MEM_BURST_ERR_EN
        ST_ERROR: begin
          done_o <= 1'b0;
          err_o  <= 1'b0;
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
